// File: rtl/perfmon_pkg.sv
// perfmon_pkg: shared state encodings, register offsets and CTRL bit positions for the cache perf monitor
package perfmon_pkg;
    typedef logic [1:0] pm_state_t;
    localparam pm_state_t PM_IDLE  = 2'd0;
    localparam pm_state_t PM_COUNT = 2'd1;
    localparam pm_state_t PM_DONE  = 2'd2;
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STOP_PC  = 8'h04;
    localparam logic [7:0] REG_CNT_BASE = 8'h08;
    localparam int CTRL_START   = 0;
    localparam int CTRL_STOP    = 1;
    localparam int CTRL_CLEAR   = 2;
    localparam int CTRL_IRQ_ACK = 3;
endpackage

// File: rtl/perf_counter_pair.sv
// perf_counter_pair: one channel's wrapping hit/miss counters with a sticky overflow flag
module perf_counter_pair #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc_hit,
    input  logic             inc_miss,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic             ovf
);
    // clear wins over counting; a hit takes priority over a miss in the same cycle
    always_ff @(posedge clk) begin
        if (Rst || clr) begin
            hits   <= '0;
            misses <= '0;
            ovf    <= 1'b0;
        end else if (en && inc_hit) begin
            hits <= hits + 1'b1;
            if (&hits) ovf <= 1'b1;
        end else if (en && inc_miss) begin
            misses <= misses + 1'b1;
            if (&misses) ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor: per-channel hit/miss counting that freezes at a programmable stop PC; PERFMON_IRQ_EN adds a stop interrupt
module cache_perf_monitor import perfmon_pkg::*; #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter logic [31:0] STOP_PC = 32'h14
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [NUM_CH-1:0] ch_access,
    input  logic [NUM_CH-1:0] ch_hit,
    input  logic [NUM_CH-1:0] ch_miss,
    input  logic [31:0]       pc,
    input  logic              pc_flush,
    input  logic              reg_wen,
    input  logic              reg_ren,
    input  logic [7:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              done,
    output logic              irq
);
    pm_state_t         state, state_nx;
    logic [31:0]       stop_pc, rd_mux;
    logic [CNT_W-1:0]  hits [NUM_CH];
    logic [CNT_W-1:0]  misses [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic ctrl_wr, do_clr, do_start, do_stop, stop_match, counting;

    assign ctrl_wr    = reg_wen && reg_addr == REG_CTRL;
    assign do_clr     = ctrl_wr && reg_wdata[CTRL_CLEAR];
    assign do_start   = ctrl_wr && reg_wdata[CTRL_START];
    assign do_stop    = ctrl_wr && reg_wdata[CTRL_STOP];
    assign counting   = state == PM_COUNT;
    assign stop_match = counting && pc == stop_pc && !pc_flush;
    assign done       = state == PM_DONE;

    // clear > start > stop; the stop-match cycle still counts because the state only changes at the edge
    always_comb begin
        state_nx = do_clr ? (do_start ? PM_COUNT : PM_IDLE) :
                   do_start ? PM_COUNT :
                   (counting && (stop_match || do_stop)) ? PM_DONE : state;
    end

    // FSM and STOP_PC register
    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= PM_IDLE;
            stop_pc <= STOP_PC;
        end else begin
            state <= state_nx;
            if (reg_wen && reg_addr == REG_STOP_PC) stop_pc <= reg_wdata;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        perf_counter_pair #(.CNT_W(CNT_W)) u_pair (
            .clk      (clk),
            .Rst      (Rst),
            .en       (counting),
            .clr      (do_clr),
            .inc_hit  (ch_access[c] && ch_hit[c]),
            .inc_miss (ch_access[c] && ch_miss[c]),
            .hits     (hits[c]),
            .misses   (misses[c]),
            .ovf      (ovf[c])
        );
    end

    // read decode; unmapped addresses fall through to zero
    always_comb begin
        rd_mux = 32'h0;
        if (reg_addr == REG_CTRL) begin
            rd_mux[8 +: NUM_CH] = ovf;
            rd_mux[1:0]         = state;
        end
        if (reg_addr == REG_STOP_PC) rd_mux = stop_pc;
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_addr == REG_CNT_BASE + 8'(8 * i))     rd_mux = 32'(hits[i]);
            if (reg_addr == REG_CNT_BASE + 8'(8 * i + 4)) rd_mux = 32'(misses[i]);
        end
    end

    // registered read port: data appears the cycle after reg_ren and reflects pre-increment counts
    always_ff @(posedge clk) begin
        if (Rst) reg_rdata <= 32'h0;
        else if (reg_ren) reg_rdata <= rd_mux;
    end

`ifdef PERFMON_IRQ_EN
    logic irq_q;
    // raised on entry to DONE, held until acknowledged; a fresh entry beats a simultaneous ack
    always_ff @(posedge clk) begin
        if (Rst) irq_q <= 1'b0;
        else if (counting && state_nx == PM_DONE) irq_q <= 1'b1;
        else if (ctrl_wr && reg_wdata[CTRL_IRQ_ACK]) irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_cache_perf_monitor.sv
// tb_cache_perf_monitor: scoreboard bench; reads push expected data, a monitor pops on each returned read
module tb_cache_perf_monitor;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              Rst = 1'b1;
    logic [NUM_CH-1:0] ch_access = '0, ch_hit = '0, ch_miss = '0;
    logic [31:0]       pc = 32'h0;
    logic              pc_flush = 1'b0;
    logic              reg_wen = 1'b0, reg_ren = 1'b0;
    logic [7:0]        reg_addr = 8'h0;
    logic [31:0]       reg_wdata = 32'h0;
    logic [31:0]       reg_rdata;
    logic              done, irq;

    cache_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STOP_PC(32'h14)) dut (
        .clk(clk), .Rst(Rst), .ch_access(ch_access), .ch_hit(ch_hit), .ch_miss(ch_miss),
        .pc(pc), .pc_flush(pc_flush), .reg_wen(reg_wen), .reg_ren(reg_ren),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    int   tests = 0;
    int   fails = 0;
    logic ren_d = 1'b0;
    logic stim_done = 1'b0;

`ifdef PERFMON_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    always @(posedge clk) ren_d <= reg_ren;

    // monitor: a read issued last cycle means reg_rdata is valid now
    initial begin
        forever begin
            @(negedge clk);
            if (ren_d) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read got=%h required=no read", reg_rdata);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (reg_rdata !== e.exp) begin
                        fails++;
                        $display("FAIL %s got=%h required=%h", e.name, reg_rdata, e.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wen = 1'b0; reg_wdata = 32'h0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        e.name = name; e.exp = exp;
        sb_q.push_back(e);
        reg_ren = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_ren = 1'b0;
    endtask

    task automatic ev(input int ch, input logic h, input logic m, input int n);
        ch_access[ch] = 1'b1; ch_hit[ch] = h; ch_miss[ch] = m;
        repeat (n) @(negedge clk);
        ch_access = '0; ch_hit = '0; ch_miss = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        Rst = 1'b0;
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rdata", reg_rdata, 32'h0);
        rd(8'h00, 32'h0, "reset_status");
        rd(8'h04, 32'h14, "reset_stop_pc");
        rd(8'h08, 32'h0, "reset_hits0");

        wr(8'h00, 32'h1);
        ev(0, 1'b1, 1'b0, 10);
        ev(0, 1'b0, 1'b1, 3);
        rd(8'h08, 32'd10, "hits0");
        rd(8'h0C, 32'd3, "misses0");
        rd(8'h00, 32'h1, "status_count");

        pc = 32'h14; pc_flush = 1'b1;
        @(negedge clk);
        chk("flush_no_stop", 32'(done), 32'h0);
        pc_flush = 1'b0; ch_access[0] = 1'b1; ch_hit[0] = 1'b1;
        @(negedge clk);
        pc = 32'h0;
        chk("stop_done", 32'(done), 32'h1);
        chk("stop_irq", 32'(irq), 32'(IRQ_ON));
        repeat (3) @(negedge clk);
        ch_access = '0; ch_hit = '0;
        rd(8'h08, 32'd11, "hits0_frozen");
        rd(8'h00, 32'h2, "status_done");
        chk("irq_held", 32'(irq), 32'(IRQ_ON));
        wr(8'h00, 32'h8);
        chk("irq_ack", 32'(irq), 32'h0);
        chk("done_after_ack", 32'(done), 32'h1);

        wr(8'h00, 32'h1);
        ev(1, 1'b1, 1'b1, 5);
        rd(8'h10, 32'd5, "hits1_both");
        rd(8'h14, 32'd0, "misses1_both");

        ev(2, 1'b1, 1'b0, 257);
        ev(3, 1'b0, 1'b0, 2);
        wr(8'h30, 32'hFFFF_FFFF);
        rd(8'h18, 32'd1, "hits2_wrap");
        rd(8'h00, 32'h401, "status_ovf");
        rd(8'h20, 32'd0, "hits3_noqual");
        rd(8'h24, 32'd0, "misses3_noqual");
        rd(8'h28, 32'd0, "unmapped");
        wr(8'h00, 32'h2);
        rd(8'h00, 32'h402, "status_ctrl_stop");
        wr(8'h00, 32'h4);
        rd(8'h18, 32'd0, "hits2_clear");
        rd(8'h08, 32'd0, "hits0_clear");
        rd(8'h00, 32'h0, "status_clear");

        wr(8'h04, 32'h100);
        rd(8'h04, 32'h100, "stop_pc_wr");
        wr(8'h00, 32'h1);
        pc = 32'h14;
        @(negedge clk);
        chk("old_pc_no_stop", 32'(done), 32'h0);
        pc = 32'h100;
        @(negedge clk);
        pc = 32'h0;
        chk("new_pc_stop", 32'(done), 32'h1);
        rd(8'h00, 32'h2, "status_new_stop");

        wr(8'h00, 32'h1);
        ev(0, 1'b1, 1'b0, 4);
        rd(8'h08, 32'd4, "hits0_before_rst");
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(8'h08, 32'd0, "rst_hits0");
        rd(8'h04, 32'h14, "rst_stop_pc");
        rd(8'h00, 32'h0, "rst_status");

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got=%0d required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
